// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, filters the synchronized lock flag,
// and releases the downstream reset only after lock has been stable long enough.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned RELOCK_TIMEOUT = 65535
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic [1:0] state,
  output logic [7:0] lock_lost_count,
  output logic [7:0] timeout_count
);

  // state      | meaning
  // PLL_RESET  | pll_rst held high for PLL_RST_CYCLES cycles
  // WAIT_LOCK  | waiting for locked_s, bounded by RELOCK_TIMEOUT
  // FILTER     | locked_s must stay high for LOCK_FILTER consecutive cycles
  // RUN        | lock accepted, sys_reset_n released
  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_FILTER    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] FLT_LAST = 16'(LOCK_FILTER - 1);
  localparam logic [15:0] TMO_LAST = 16'(RELOCK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync1_d;
  logic        locked_s_q, locked_s_d;
  logic        pll_rst_q, pll_rst_d;
  logic        sys_reset_n_q, sys_reset_n_d;
  logic [7:0]  lost_q, lost_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        lost_inc;
  logic        tmo_inc;

  always_comb begin
    sync1_d    = pll_locked;
    locked_s_d = sync1_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    lost_inc = 1'b0;
    tmo_inc  = 1'b0;
    case (state_q)
      ST_PLL_RESET: begin
        // lock flag deliberately ignored here so the pulse always completes
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_FILTER;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_PLL_RESET;
          cnt_d   = '0;
          tmo_inc = 1'b1;
        end
      end
      ST_FILTER: begin
        if (!locked_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FLT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s_q) begin
          state_d  = ST_PLL_RESET;
          lost_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pll_rst_d     = (state_d == ST_PLL_RESET);
    sys_reset_n_d = (state_d == ST_RUN);
    lost_d        = (lost_inc && (lost_q != 8'hFF)) ? lost_q + 8'd1 : lost_q;
    tmo_d         = (tmo_inc && (tmo_q != 8'hFF)) ? tmo_q + 8'd1 : tmo_q;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PLL_RESET;
      cnt_q         <= '0;
      sync1_q       <= 1'b0;
      locked_s_q    <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lost_q        <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync1_q       <= sync1_d;
      locked_s_q    <= locked_s_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      lost_q        <= lost_d;
      tmo_q         <= tmo_d;
    end
  end

  assign state           = state_q;
  assign pll_rst         = pll_rst_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign lock_lost_count = lost_q;
  assign timeout_count   = tmo_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with PLL_RST_CYCLES=4, LOCK_FILTER=8,
// RELOCK_TIMEOUT=32; expected cycle positions are worked out by hand.
module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset_n;
  logic [1:0] state;
  logic [7:0] lock_lost_count;
  logic [7:0] timeout_count;

  int vectors;
  int miscompares;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .LOCK_FILTER(8),
    .RELOCK_TIMEOUT(32)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n),
    .state(state),
    .lock_lost_count(lock_lost_count),
    .timeout_count(timeout_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    repeat (2) @(posedge refclk);
    @(negedge refclk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int n;
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    repeat (3) @(posedge refclk);
    #1;
    vectors++;
    if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state); end
    vectors++;
    if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL reset_pll_rst got %b want 1", pll_rst); end
    vectors++;
    if (sys_reset_n !== 1'b0) begin miscompares++; $display("FAIL reset_sys_reset_n got %b want 0", sys_reset_n); end
    vectors++;
    if (lock_lost_count !== 8'd0 || timeout_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", lock_lost_count, timeout_count);
    end
    @(negedge refclk) rst_n = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge refclk); #1; n++;
      if (pll_rst !== 1'b1) break;
    end
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL reset_pulse_width_locked_high got %0d want 4", n); end
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL reset_after_pulse_state got %0d want 1", state); end
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL reset_enter_filter got %0d want 2", state); end
  endtask

  task automatic test_lock_acquire();
    int n;
    apply_reset();
    n = 0;
    while (n < 20) begin
      @(posedge refclk); #1; n++;
      if (pll_rst !== 1'b1) break;
    end
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL acquire_pulse_width got %0d want 4", n); end
    repeat (6) @(posedge refclk);
    @(negedge refclk) pll_locked = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge refclk); #1; n++;
      vectors++;
      if (sys_reset_n !== (state == 2'd3)) begin
        miscompares++;
        $display("FAIL acquire_sysrst_vs_state got %b state %0d", sys_reset_n, state);
      end
      if (sys_reset_n === 1'b1) break;
    end
    vectors++;
    if (n != 11) begin miscompares++; $display("FAIL acquire_latency got %0d want 11", n); end
    vectors++;
    if (state !== 2'd3) begin miscompares++; $display("FAIL acquire_state got %0d want 3", state); end
  endtask

  task automatic test_timeout();
    int last_rise;
    int rises;
    logic prev;
    apply_reset();
    last_rise = 0;
    rises     = 0;
    prev      = 1'b1;
    for (int cyc = 1; cyc <= 108; cyc++) begin
      @(posedge refclk); #1;
      vectors++;
      if (sys_reset_n !== 1'b0) begin miscompares++; $display("FAIL timeout_sysrst cyc %0d got %b want 0", cyc, sys_reset_n); end
      if (pll_rst === 1'b1 && prev === 1'b0) begin
        rises++;
        vectors++;
        if (cyc - last_rise != 36) begin miscompares++; $display("FAIL timeout_period got %0d want 36", cyc - last_rise); end
        last_rise = cyc;
      end
      if (pll_rst === 1'b0 && prev === 1'b1) begin
        vectors++;
        if (cyc - last_rise != 4) begin miscompares++; $display("FAIL timeout_width got %0d want 4", cyc - last_rise); end
      end
      if (cyc == 107) begin
        vectors++;
        if (timeout_count !== 8'd2) begin miscompares++; $display("FAIL timeout_count_before got %0d want 2", timeout_count); end
      end
      prev = pll_rst;
    end
    vectors++;
    if (rises != 3) begin miscompares++; $display("FAIL timeout_rises got %0d want 3", rises); end
    vectors++;
    if (timeout_count !== 8'd3) begin miscompares++; $display("FAIL timeout_count got %0d want 3", timeout_count); end
  endtask

  task automatic test_reset_in_filter();
    int n;
    n = 0;
    while (state !== 2'd1 && n < 10) begin @(posedge refclk); #1; n++; end
    @(negedge refclk) pll_locked = 1'b1;
    n = 0;
    while (state !== 2'd2 && n < 10) begin @(posedge refclk); #1; n++; end
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL filter_reach got %0d want 2", state); end
    vectors++;
    if (timeout_count !== 8'd3) begin miscompares++; $display("FAIL filter_pre_count got %0d want 3", timeout_count); end
    repeat (2) @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== 2'd0 || pll_rst !== 1'b1 || sys_reset_n !== 1'b0) begin
      miscompares++;
      $display("FAIL filter_async_reset got state %0d pll_rst %b sys_reset_n %b want 0 1 0", state, pll_rst, sys_reset_n);
    end
    vectors++;
    if (timeout_count !== 8'd0 || lock_lost_count !== 8'd0) begin
      miscompares++;
      $display("FAIL filter_async_counts got %0d/%0d want 0/0", timeout_count, lock_lost_count);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    apply_reset();
    @(negedge refclk) pll_locked = 1'b1;
    n = 0;
    while (state !== 2'd3 && n < 40) begin @(posedge refclk); #1; n++; end
    vectors++;
    if (state !== 2'd3) begin miscompares++; $display("FAIL loss_reach_run got %0d want 3", state); end
    @(negedge refclk) pll_locked = 1'b0;
    @(posedge refclk); #1;
    @(negedge refclk) pll_locked = 1'b1;
    @(posedge refclk); #1;
    vectors++;
    if (sys_reset_n !== 1'b1 || state !== 2'd3) begin
      miscompares++;
      $display("FAIL loss_p2 got sys_reset_n %b state %0d want 1 3", sys_reset_n, state);
    end
    @(posedge refclk); #1;
    vectors++;
    if (pll_rst !== 1'b1 || sys_reset_n !== 1'b0 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL loss_p3 got pll_rst %b sys_reset_n %b state %0d want 1 0 0", pll_rst, sys_reset_n, state);
    end
    vectors++;
    if (lock_lost_count !== 8'd1) begin miscompares++; $display("FAIL loss_count got %0d want 1", lock_lost_count); end
    repeat (3) @(posedge refclk); #1;
    vectors++;
    if (pll_rst !== 1'b1) begin miscompares++; $display("FAIL loss_full_pulse got %b want 1", pll_rst); end
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd1 || pll_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_wait_lock got state %0d pll_rst %b want 1 0", state, pll_rst);
    end
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL loss_filter got %0d want 2", state); end
    repeat (7) @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd2 || sys_reset_n !== 1'b0) begin
      miscompares++;
      $display("FAIL loss_filter_end got state %0d sys_reset_n %b want 2 0", state, sys_reset_n);
    end
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd3 || sys_reset_n !== 1'b1) begin
      miscompares++;
      $display("FAIL loss_relock got state %0d sys_reset_n %b want 3 1", state, sys_reset_n);
    end
  endtask

  task automatic test_glitch();
    int n;
    apply_reset();
    n = 0;
    while (pll_rst !== 1'b0 && n < 20) begin @(posedge refclk); #1; n++; end
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL glitch_wait_lock got %0d want 1", state); end
    @(negedge refclk) pll_locked = 1'b1;
    repeat (7) @(posedge refclk);
    @(negedge refclk) pll_locked = 1'b0;
    @(posedge refclk);
    @(negedge refclk) pll_locked = 1'b1;
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL glitch_filter_cnt6 got %0d want 2", state); end
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd1) begin miscompares++; $display("FAIL glitch_back_to_wait got %0d want 1", state); end
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd2) begin miscompares++; $display("FAIL glitch_refilter got %0d want 2", state); end
    repeat (7) @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd2 || sys_reset_n !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_no_credit got state %0d sys_reset_n %b want 2 0", state, sys_reset_n);
    end
    @(posedge refclk); #1;
    vectors++;
    if (state !== 2'd3 || sys_reset_n !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_run got state %0d sys_reset_n %b want 3 1", state, sys_reset_n);
    end
  endtask

  task automatic test_saturation();
    int n;
    int stalls;
    apply_reset();
    @(negedge refclk) pll_locked = 1'b1;
    stalls = 0;
    for (int loss = 1; loss <= 300; loss++) begin
      n = 0;
      while (state !== 2'd3 && n < 40) begin @(posedge refclk); #1; n++; end
      if (state !== 2'd3) stalls++;
      @(negedge refclk) pll_locked = 1'b0;
      @(negedge refclk) pll_locked = 1'b1;
      n = 0;
      while (state !== 2'd0 && n < 10) begin @(posedge refclk); #1; n++; end
      if (state !== 2'd0) stalls++;
      if (loss == 254) begin
        vectors++;
        if (lock_lost_count !== 8'd254) begin miscompares++; $display("FAIL sat_254 got %0d want 254", lock_lost_count); end
      end
      if (loss == 255) begin
        vectors++;
        if (lock_lost_count !== 8'd255) begin miscompares++; $display("FAIL sat_255 got %0d want 255", lock_lost_count); end
      end
    end
    vectors++;
    if (stalls != 0) begin miscompares++; $display("FAIL sat_wait_budget got %0d stalls want 0", stalls); end
    vectors++;
    if (lock_lost_count !== 8'd255) begin miscompares++; $display("FAIL sat_300 got %0d want 255", lock_lost_count); end
    vectors++;
    if (timeout_count !== 8'd0) begin miscompares++; $display("FAIL sat_timeout_count got %0d want 0", timeout_count); end
  endtask

  task automatic test_reset_in_run();
    int n;
    n = 0;
    while (state !== 2'd3 && n < 40) begin @(posedge refclk); #1; n++; end
    vectors++;
    if (state !== 2'd3 || sys_reset_n !== 1'b1) begin
      miscompares++;
      $display("FAIL run_reach got state %0d sys_reset_n %b want 3 1", state, sys_reset_n);
    end
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== 2'd0 || pll_rst !== 1'b1 || sys_reset_n !== 1'b0) begin
      miscompares++;
      $display("FAIL run_async_reset got state %0d pll_rst %b sys_reset_n %b want 0 1 0", state, pll_rst, sys_reset_n);
    end
    vectors++;
    if (lock_lost_count !== 8'd0 || timeout_count !== 8'd0) begin
      miscompares++;
      $display("FAIL run_async_counts got %0d/%0d want 0/0", lock_lost_count, timeout_count);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    pll_locked  = 1'b0;
    test_reset();
    test_lock_acquire();
    test_timeout();
    test_reset_in_filter();
    test_lock_loss();
    test_glitch();
    test_saturation();
    test_reset_in_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
